// File: rtl/dvi_char_fetch_sched.sv
// Character RAM arbiter for the DVI text overlay: burst-fetches one character row
// into the line buffer during horizontal blanking and grants the RAM to the host otherwise.
module dvi_char_fetch_sched #(
    parameter int COLS     = 80,
    parameter int ROWS     = 60,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int ADDR_W   = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [11:0]       h_cnt,
    input  logic [11:0]       v_cnt,
    input  logic              host_valid,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_data,
    output logic              host_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              line_wr_en,
    output logic [6:0]        line_wr_idx,
    output logic [7:0]        line_wr_data,
    output logic              frame_start,
    output logic              fetch_overrun
);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [11:0]       H_TRIG    = 12'(H_ACTIVE);
    localparam logic [11:0]       V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0]       V_ROW_END = 12'(8 * ROWS - 1);
    localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    // One bit wider so COLS*ROWS == 2^ADDR_W cannot wrap to zero.
    localparam logic [ADDR_W:0]   CELLS     = (ADDR_W + 1)'(COLS * ROWS);

    state_t            state_r, state_s;
    logic [6:0]        col_r;
    logic [ADDR_W-1:0] base_r;
    logic              init_done_r;
    logic              line_wr_en_r;
    logic [6:0]        line_wr_idx_r;
    logic              frame_start_r;
    logic              fetch_overrun_r;
    logic              trig_s;
    logic              host_ready_s;
    logic              host_wr_s;

    assign trig_s = (h_cnt == H_TRIG) &&
                    ((v_cnt == V_LAST) || ((v_cnt[2:0] == 3'd7) && (v_cnt < V_ROW_END)));

    // Next-state logic of the fetch sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (trig_s) state_s = FETCH;
                else        state_s = IDLE;
            end
            FETCH: begin
                if (col_r == COL_LAST) state_s = DRAIN;
                else                   state_s = FETCH;
            end
            DRAIN:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state, column counter and row base; base moves only on an accepted trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            col_r   <= 7'd0;
            base_r  <= '0;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && trig_s) begin
                col_r  <= 7'd0;
                base_r <= (v_cnt == V_LAST) ? '0 : base_r + COLS_A;
            end else if (state_r == FETCH) begin
                col_r  <= col_r + 7'd1;
            end
        end
    end

    // Line-buffer write tracks the read issued one cycle earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_wr_en_r  <= 1'b0;
            line_wr_idx_r <= 7'd0;
        end else begin
            line_wr_en_r <= (state_r == FETCH);
            if (state_r == FETCH) line_wr_idx_r <= col_r;
        end
    end

    // Init, frame pulse and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_r     <= 1'b0;
            frame_start_r   <= 1'b0;
            fetch_overrun_r <= 1'b0;
        end else begin
            init_done_r   <= 1'b1;
            frame_start_r <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
            if (trig_s && (state_r != IDLE)) fetch_overrun_r <= 1'b1;
        end
    end

    assign host_ready_s = init_done_r && (state_r == IDLE) && !trig_s;
    assign host_wr_s    = host_valid && host_ready_s && ({1'b0, host_addr} < CELLS);

    // RAM port mux: fetch reads take priority; host writes pass through on the handshake edge.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'd0;
        if (state_r == FETCH) begin
            mem_en   = 1'b1;
            mem_addr = base_r + ADDR_W'(col_r);
        end else if (host_wr_s) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = host_addr;
            mem_wdata = host_data;
        end else begin
            mem_en = 1'b0;
        end
    end

    assign host_ready    = host_ready_s;
    assign line_wr_en    = line_wr_en_r;
    assign line_wr_idx   = line_wr_idx_r;
    assign line_wr_data  = line_wr_en_r ? mem_rdata : 8'd0;
    assign frame_start   = frame_start_r;
    assign fetch_overrun = fetch_overrun_r;

endmodule
